multicycle_microprocessor: RTL and testbench
============================================

MULTICYCLE_MICROPROCESSOR -- requirements
Module: multicycle_microprocessor

Interface
REQ-001 Parameter DATA_W, default 8: datapath, register and memory word width; legal range 8..32.
REQ-002 Parameter PC_W, default 8: program counter width.
REQ-003 Parameter DMEM_DEPTH, default 16: data memory words; power of 2, at most 2^DATA_W.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 inst_valid  input  1  instruction word present on instruction.
REQ-007 instruction  input  8  op[7:6], rs[5:4], rt[3:2], rd/imm[1:0].
REQ-008 inst_ready  output  1  core accepts an instruction this cycle.
REQ-009 pc  output  PC_W  address of the instruction being fetched or executed.
REQ-010 retire  output  1  one-cycle pulse when an instruction completes.
REQ-011 wb_data  output  DATA_W  last value written to the register file.
REQ-012 lowerHex, higherHex  output  7 each  7-segment images of wb_data[3:0] and wb_data[7:4].
REQ-013 flags  output  2  [0] halt (self-branch), [1] sticky signed overflow.

Function
REQ-014 ISA: op 00 ADD rd<=rs+rt; 01 LOAD rt<=mem[rs+sext(imm)]; 10 STORE mem[rs+sext(imm)]<=rt; 11 BRANCH pc<=pc+1+sext(imm).
REQ-015 imm = instruction[1:0], sign-extended to DATA_W (ALU) or PC_W (branch); range -2..+1.
REQ-016 Four registers r0..r3, each DATA_W wide; all writable, r0 not hardwired.
REQ-017 FSM states: FETCH, EXEC, MEM, WB, HALT.
REQ-018 FETCH: inst_ready=1; on inst_valid, latch instruction and go to EXEC; otherwise stay in FETCH.
REQ-019 EXEC: ADD computes, then WB; LOAD/STORE compute address, then MEM; BRANCH updates pc, pulses retire, then FETCH, or HALT when imm = -1 (self-branch).
REQ-020 MEM: LOAD reads, then WB; STORE writes, pulses retire, increments pc, then FETCH.
REQ-021 WB: write the register, update wb_data, pulse retire, increment pc, then FETCH.
REQ-022 Latency from acceptance to retire: ADD 3 cycles, LOAD 4, STORE 3, BRANCH 2.
REQ-023 Memory address = ALU result modulo DMEM_DEPTH (low log2(DMEM_DEPTH) bits).
REQ-024 ADD sets flags[1] on signed overflow; the flag is sticky until reset. Address adds never set it.
REQ-025 ADD result wraps modulo 2^DATA_W; pc wraps modulo 2^PC_W on both increment and branch.
REQ-026 inst_ready=0 in every state except FETCH; inst_valid outside FETCH is ignored.
REQ-027 HALT: flags[0]=1, inst_ready=0, no register or memory writes; only reset exits.
REQ-028 A read of a register written by the previous instruction returns the new value, since the core is not pipelined.

Reset
REQ-029 Asserting reset at any time, including mid-instruction, immediately forces:
- state=FETCH, pc=0, r0..r3=0, wb_data=0, flags=00, retire=0
- data memory cleared to 0
- the in-flight instruction discarded, with no write and no retire
REQ-030 inst_ready rises in the first cycle after reset deasserts.

Structure
REQ-031 Shared package mcp_pkg holds:
- opcode constants
- FSM state enum
- sign-extend function
- team-standard 7-segment encode function
REQ-032 Register file is one sub-module, mcp_regfile (2 read ports, 1 write port, async reset); ALU, FSM and data memory stay inline.

Verification
REQ-033 Reset, ADD r1<=r0+r0, then ADD r2<=r1+r1 -> retire after 3 cycles each; wb_data=0; pc=2.
REQ-034 Preload via LOAD, r1=0x7F and r2=0x01, then ADD r3<=r1+r2 (DATA_W=8) -> wb_data=0x80, flags[1]=1; flag still set after a later non-overflowing ADD.
REQ-035 STORE r2 to [r1-2], then LOAD r3 from [r1-2] -> r3=r2; LOAD retire 4 cycles after acceptance.
REQ-036 BRANCH imm=+1 at pc=5 -> pc=7 after 2 cycles; BRANCH imm=-1 -> HALT, flags[0]=1, inst_ready held 0.
REQ-037 inst_valid held low in FETCH for 10 cycles -> no state change; inst_valid pulsed during EXEC -> ignored.
REQ-038 Reset asserted in the MEM state of a STORE -> memory unchanged (0), pc=0, flags=00; then rerun REQ-033 with DATA_W=16, PC_W=10.

Source files
------------

// File: rtl/mcp_pkg.sv
// Shared definitions for the multicycle microprocessor: opcodes, FSM states,
// immediate sign extension and the 7-segment encoder.
package mcp_pkg;

  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_STORE  = 2'b10;
  localparam logic [1:0] OP_BRANCH = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_MEM   = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  // 2-bit immediate widened to 32 bits; callers truncate to their width
  function automatic logic [31:0] sext2(input logic [1:0] imm);
    return {{30{imm[1]}}, imm};
  endfunction

  // Active-high segments, bit 0 = a ... bit 6 = g
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_microprocessor_if.sv
// Instruction stream and status bus of the core. The instruction source is the
// master; the core is the slave.
interface multicycle_microprocessor_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
);
  logic              inst_valid;
  logic [7:0]        instruction;
  logic              inst_ready;
  logic [PC_W-1:0]   pc;
  logic              retire;
  logic [DATA_W-1:0] wb_data;
  logic [6:0]        lowerHex;
  logic [6:0]        higherHex;
  logic [1:0]        flags;

  modport master (
    output inst_valid, instruction,
    input  inst_ready, pc, retire, wb_data, lowerHex, higherHex, flags
  );

  modport slave (
    input  inst_valid, instruction,
    output inst_ready, pc, retire, wb_data, lowerHex, higherHex, flags
  );
endinterface

// File: rtl/mcp_regfile.sv
// Four-entry register file: two asynchronous read ports, one write port.
module mcp_regfile #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        raddr_a,
  input  logic [1:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DATA_W-1:0] wdata
);
  logic [3:0][DATA_W-1:0] regs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  regs <= '0;
    else if (we) regs[waddr] <= wdata;
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
endmodule

// File: rtl/multicycle_microprocessor.sv
// Non-pipelined 4-instruction core: FETCH -> EXEC -> [MEM] -> [WB], with a
// resettable data memory and a sticky signed-overflow flag.
module multicycle_microprocessor
  import mcp_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PC_W       = 8,
  parameter int DMEM_DEPTH = 16
) (
  input  logic clk,
  input  logic reset,
  multicycle_microprocessor_if.slave bus
);
  localparam int AW = $clog2(DMEM_DEPTH);

  state_e            state;
  logic [7:0]        ir;
  logic [PC_W-1:0]   pc_q;
  logic [DATA_W-1:0] alu_q, wb_q;
  logic              ovf, retire_q;

  logic [1:0]        op, wa;
  logic [DATA_W-1:0] rs_d, rt_d, sum, addr_sum, imm_d, mem_rdata;
  logic [PC_W-1:0]   imm_p;
  logic [AW-1:0]     mem_addr;
  logic              add_ovf, we, mem_we;

  logic [DATA_W-1:0] dmem [DMEM_DEPTH];

  assign op       = ir[7:6];
  assign imm_d    = DATA_W'(sext2(ir[1:0]));
  assign imm_p    = PC_W'(sext2(ir[1:0]));
  assign sum      = rs_d + rt_d;
  assign addr_sum = rs_d + imm_d;
  assign add_ovf  = (rs_d[DATA_W-1] == rt_d[DATA_W-1]) && (sum[DATA_W-1] != rs_d[DATA_W-1]);

  // alu_q doubles as the load-data holding register between MEM and WB
  assign we       = (state == S_WB);
  assign wa       = (op == OP_ADD) ? ir[1:0] : ir[3:2];
  assign mem_addr = alu_q[AW-1:0];
  assign mem_we   = (state == S_MEM) && (op == OP_STORE);
  assign mem_rdata = dmem[mem_addr];

  mcp_regfile #(.DATA_W(DATA_W)) u_rf (
    .clk     (clk),
    .reset   (reset),
    .raddr_a (ir[5:4]),
    .raddr_b (ir[3:2]),
    .rdata_a (rs_d),
    .rdata_b (rt_d),
    .we      (we),
    .waddr   (wa),
    .wdata   (alu_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH;
      ir       <= '0;
      pc_q     <= '0;
      alu_q    <= '0;
      wb_q     <= '0;
      ovf      <= 1'b0;
      retire_q <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      case (state)
        S_FETCH: if (bus.inst_valid) begin
          ir    <= bus.instruction;
          state <= S_EXEC;
        end
        S_EXEC: case (op)
          OP_ADD: begin
            alu_q <= sum;
            ovf   <= ovf | add_ovf;
            state <= S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_q <= addr_sum;
            state <= S_MEM;
          end
          default: begin
            pc_q     <= pc_q + PC_W'(1) + imm_p;
            retire_q <= 1'b1;
            state    <= (ir[1:0] == 2'b11) ? S_HALT : S_FETCH;
          end
        endcase
        S_MEM: if (op == OP_LOAD) begin
          alu_q <= mem_rdata;
          state <= S_WB;
        end else begin
          retire_q <= 1'b1;
          pc_q     <= pc_q + PC_W'(1);
          state    <= S_FETCH;
        end
        S_WB: begin
          wb_q     <= alu_q;
          retire_q <= 1'b1;
          pc_q     <= pc_q + PC_W'(1);
          state    <= S_FETCH;
        end
        default: state <= S_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
    end else if (mem_we) begin
      dmem[mem_addr] <= rt_d;
    end
  end

  // Gating with reset keeps ready low until the first cycle after release
  assign bus.inst_ready = reset && (state == S_FETCH);
  assign bus.pc         = pc_q;
  assign bus.retire     = retire_q;
  assign bus.wb_data    = wb_q;
  assign bus.lowerHex   = seg7(wb_q[3:0]);
  assign bus.higherHex  = seg7(wb_q[7:4]);
  assign bus.flags      = {ovf, state == S_HALT};
endmodule

// File: tb/tb_multicycle_microprocessor.sv
// Scoreboard bench: an ISA model pushes expected retire results per issued
// instruction; a negedge monitor pops and compares them on each retire pulse.
module tb_multicycle_microprocessor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_microprocessor_if #(.DATA_W(8),  .PC_W(8))  b8 ();
  multicycle_microprocessor_if #(.DATA_W(16), .PC_W(10)) b16 ();

  multicycle_microprocessor #(.DATA_W(8), .PC_W(8), .DMEM_DEPTH(16)) u8 (
    .clk(clk), .reset(rst_n), .bus(b8));
  multicycle_microprocessor #(.DATA_W(16), .PC_W(10), .DMEM_DEPTH(16)) u16 (
    .clk(clk), .reset(rst_n), .bus(b16));

  typedef struct {
    int          sel;
    string       tag;
    time         t0;
    logic [31:0] wb;
    logic [31:0] pc;
    logic [1:0]  flags;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [31:0] m_reg [4];
  logic [31:0] m_mem [16];
  logic [31:0] m_pc, m_wb;
  logic        m_ovf, m_halt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = '0;
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_pc = '0; m_wb = '0; m_ovf = 1'b0; m_halt = 1'b0;
  endtask

  task automatic model_step(input int sel, input logic [7:0] ins, input bit frc,
                            input logic [31:0] fval, output int lat);
    int dw, pw, im, a;
    logic [31:0] dm, pm, s, x, y;
    dw = sel ? 16 : 8;
    pw = sel ? 10 : 8;
    dm = (32'd1 << dw) - 32'd1;
    pm = (32'd1 << pw) - 32'd1;
    im = ins[1] ? int'(ins[1:0]) - 4 : int'(ins[1:0]);
    x  = m_reg[ins[5:4]];
    y  = m_reg[ins[3:2]];
    a  = (int'(x) + im) & 15;
    lat = 0;
    case (ins[7:6])
      2'b00: begin
        s = (x + y) & dm;
        if (x[dw-1] == y[dw-1] && s[dw-1] != x[dw-1]) m_ovf = 1'b1;
        m_reg[ins[1:0]] = s; m_wb = s; m_pc = (m_pc + 32'd1) & pm; lat = 3;
      end
      2'b01: begin
        s = frc ? fval : m_mem[a];
        m_reg[ins[3:2]] = s; m_wb = s; m_pc = (m_pc + 32'd1) & pm; lat = 4;
      end
      2'b10: begin
        m_mem[a] = y; m_pc = (m_pc + 32'd1) & pm; lat = 3;
      end
      default: begin
        m_pc = (m_pc + 32'd1 + 32'(im)) & pm;
        if (im == -1) m_halt = 1'b1;
        lat = 2;
      end
    endcase
  endtask

  function automatic logic rdy(input int sel);
    return sel ? b16.inst_ready : b8.inst_ready;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [7:0] ins);
    if (sel != 0) begin b16.inst_valid = v; b16.instruction = ins; end
    else          begin b8.inst_valid  = v; b8.instruction  = ins; end
  endtask

  task automatic issue(input int sel, input logic [7:0] ins, input bit frc,
                       input logic [31:0] fval, input bit glitch, input string tag);
    exp_t e;
    int lat, n;
    @(negedge clk);
    n = 0;
    while (!rdy(sel) && n < 20) begin @(negedge clk); n++; end
    if (!rdy(sel)) begin chk({tag, "_ready"}, 32'd0, 32'd1); return; end
    model_step(sel, ins, frc, fval, lat);
    e.sel = sel; e.tag = tag; e.t0 = $time; e.wb = m_wb; e.pc = m_pc;
    e.flags = {m_ovf, m_halt}; e.lat = lat;
    sb.push_back(e);
    drive(sel, 1'b1, ins);
    @(negedge clk);
    // a self-branch here would halt the core if the core wrongly accepted it
    if (glitch) begin drive(sel, 1'b1, 8'hC3); @(negedge clk); end
    drive(sel, 1'b0, 8'h00);
    n = 0;
    while (sb.size() != 0 && n < 20) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin chk({tag, "_timeout"}, sb.size(), 32'd0); sb.delete(); end
  endtask

  task automatic sb_pop(input int sel);
    exp_t e;
    logic [31:0] wb, pc, fl, lo, hi;
    if (sel != 0) begin
      wb = 32'(b16.wb_data); pc = 32'(b16.pc); fl = 32'(b16.flags);
      lo = 32'(b16.lowerHex); hi = 32'(b16.higherHex);
    end else begin
      wb = 32'(b8.wb_data); pc = 32'(b8.pc); fl = 32'(b8.flags);
      lo = 32'(b8.lowerHex); hi = 32'(b8.higherHex);
    end
    if (sb.size() == 0) begin chk("spurious_retire", 32'd1, 32'd0); return; end
    e = sb.pop_front();
    chk({e.tag, "_sel"},   32'(sel), 32'(e.sel));
    chk({e.tag, "_lat"},   32'(($time - e.t0) / 10), 32'(e.lat));
    chk({e.tag, "_wb"},    wb, e.wb);
    chk({e.tag, "_pc"},    pc, e.pc);
    chk({e.tag, "_flags"}, fl, 32'(e.flags));
    chk({e.tag, "_hexlo"}, lo, 32'(seg_tab[e.wb[3:0]]));
    chk({e.tag, "_hexhi"}, hi, 32'(seg_tab[e.wb[7:4]]));
  endtask

  always @(negedge clk) begin
    if (b8.retire)  sb_pop(0);
    if (b16.retire) sb_pop(1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_pc",     32'(b8.pc), 32'd0);
    chk("rst_wb",     32'(b8.wb_data), 32'd0);
    chk("rst_flags",  32'(b8.flags), 32'd0);
    chk("rst_retire", 32'(b8.retire), 32'd0);
    chk("rst_ready",  32'(b8.inst_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(b8.inst_ready), 32'd1);
    chk("rst_hexlo",       32'(b8.lowerHex), 32'h3F);

    repeat (10) @(negedge clk);
    chk("idle_pc",    32'(b8.pc), 32'd0);
    chk("idle_ready", 32'(b8.inst_ready), 32'd1);

    issue(0, 8'h01, 0, 0, 0, "add_r0r0");
    issue(0, 8'h16, 0, 0, 0, "add_r1r1");
    issue(0, 8'h16, 0, 0, 1, "add_glitch");

    force u8.mem_rdata = 8'h7F;
    issue(0, 8'h44, 1, 32'h7F, 0, "load_7f");
    release u8.mem_rdata;
    force u8.mem_rdata = 8'h01;
    issue(0, 8'h48, 1, 32'h01, 0, "load_01");
    release u8.mem_rdata;

    issue(0, 8'h1B, 0, 0, 0, "add_ovf");
    issue(0, 8'h28, 0, 0, 0, "add_sticky");
    issue(0, 8'h9A, 0, 0, 0, "store_r2");
    issue(0, 8'h5E, 0, 0, 0, "load_back");
    issue(0, 8'h5D, 0, 0, 0, "load_wrap");
    issue(0, 8'hC2, 0, 0, 0, "branch_back");

    // STORE r1 (0x7F) to [r0-2] = addr 0, reset while it sits in MEM
    @(negedge clk);
    drive(0, 1'b1, 8'h86);
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_pc",     32'(b8.pc), 32'd0);
    chk("midrst_flags",  32'(b8.flags), 32'd0);
    chk("midrst_retire", 32'(b8.retire), 32'd0);
    chk("midrst_wb",     32'(b8.wb_data), 32'd0);
    chk("midrst_ready",  32'(b8.inst_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    issue(0, 8'h44, 0, 0, 0, "load_after_rst");

    issue(0, 8'hC2, 0, 0, 0, "branch_to0");
    issue(0, 8'hC2, 0, 0, 0, "branch_wrap");
    issue(0, 8'h01, 0, 0, 0, "add_pcwrap");
    for (int i = 0; i < 5; i++) issue(0, 8'h01, 0, 0, 0, "add_fill");
    issue(0, 8'hC1, 0, 0, 0, "branch_p1");
    issue(0, 8'hC3, 0, 0, 0, "branch_halt");

    drive(0, 1'b1, 8'h01);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("halt_ready", 32'(b8.inst_ready), 32'd0);
    end
    drive(0, 1'b0, 8'h00);
    chk("halt_pc",    32'(b8.pc), 32'd7);
    chk("halt_flags", 32'(b8.flags), 32'd1);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    chk("halt_exit_flags", 32'(b8.flags), 32'd0);
    chk("halt_exit_ready", 32'(b8.inst_ready), 32'd1);
    chk("w16_rst_pc",      32'(b16.pc), 32'd0);

    issue(1, 8'h01, 0, 0, 0, "w16_add_r0r0");
    issue(1, 8'h16, 0, 0, 0, "w16_add_r1r1");
    issue(1, 8'hC2, 0, 0, 0, "w16_branch_m2a");
    issue(1, 8'hC2, 0, 0, 0, "w16_branch_m2b");
    issue(1, 8'hC2, 0, 0, 0, "w16_branch_wrap");
    issue(1, 8'h01, 0, 0, 0, "w16_add_pcwrap");

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
